l2_backing_memory: RTL
======================

# l2_backing_memory

Word-organised backing store that sits directly downstream of `dcache` and answers its L2 request port. Loads complete after a fixed, parameterised latency; stores write in one cycle. Words never written since reset read back as a fixed fill pattern. Free-running load and store counters support bench checking.

## Interface
- `XLEN`, 32, data and address width in bits
- `DEPTH_WORDS`, 1024, number of XLEN-bit words stored; power of two
- `LOAD_LATENCY`, 4, cycles from load acceptance to response; legal range 1–255
- `FILL_WORD`, 32'hABAC_0012, data returned for a word not written since reset

- `clk`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-low reset
- `l2_req_address`  in  XLEN  byte address from dcache
- `l2_req_type`  in  memory_operation_e  LOAD or STORE
- `l2_req_valid`  in  1  request present; held by dcache until served
- `l2_word_to_store`  in  XLEN  store data
- `l2_fetched_word`  out  XLEN  load data; valid only while `l2_fetched_word_valid` is high
- `l2_fetched_word_valid`  out  1  one-cycle load-completion pulse
- `load_count`  out  32  loads completed since reset; wraps at 2^32
- `store_count`  out  32  stores performed since reset; wraps at 2^32

## Operation
- Word index is `l2_req_address[log2(DEPTH_WORDS)+1:2]`.
  - Bits [1:0] are ignored, so requests are word-aligned.
  - Upper bits are ignored, so the index wraps modulo DEPTH_WORDS.
- Storage: a data array plus one written bit per word.
  - Reset clears every written bit.
  - Data array contents are not reset.
- State machine: IDLE, WAIT, RESP.
- IDLE
  - `l2_req_valid` && STORE:
    - Write `l2_word_to_store` into data[idx] and set written[idx].
    - Increment `store_count`.
    - Stay in IDLE.
    - If the store is held for N cycles, it is rewritten each cycle and counted N times. This is idempotent for the data; dcache must drop `l2_req_valid` or change the request after one cycle.
  - `l2_req_valid` && LOAD:
    - Latch the index.
    - Load the latency counter with LOAD_LATENCY-1.
    - Go to WAIT.
  - Otherwise stay in IDLE.
- WAIT
  - Decrement the counter each cycle.
  - At 0, go to RESP.
  - Request inputs are ignored.
  - The latched index is used even if `l2_req_address` changes.
  - A drop of `l2_req_valid` does not abort the load.
- RESP
  - `l2_fetched_word_valid` = 1 for exactly this cycle.
  - `l2_fetched_word` = written[idx] ? data[idx] : FILL_WORD.
  - Increment `load_count`.
  - Go to IDLE unconditionally. Requests are not sampled in RESP.
- Store during WAIT or RESP: not accepted. A request held by dcache is taken in the next IDLE cycle.
- Reset (`reset`==0 at a rising edge), including mid-load:
  - State goes to IDLE.
  - Any pending load is discarded with no response.
  - Counters go to 0.
  - Written bits are cleared.

## Timing
- Reset values:
  - `l2_fetched_word_valid` = 0
  - `l2_fetched_word` = 0
  - `load_count` = 0
  - `store_count` = 0
- Outputs are registered. `l2_fetched_word` holds its last value outside RESP.
- Load accepted at edge T:
  - The state sequence is IDLE(T) → WAIT for LOAD_LATENCY-1 cycles → RESP.
  - Response valid during cycle T+LOAD_LATENCY.
  - LOAD_LATENCY=1 skips WAIT, giving IDLE → RESP.
- Back-to-back loads (dcache line fill, valid held, address advanced after each response): each word costs LOAD_LATENCY+1 cycles.
- A store that becomes visible at edge T is returned by a load accepted at edge T+1 or later.

## Test plan
- **Reset then unwritten load:** `reset` low 5 cycles, then LOAD 0x0000_0040 with LOAD_LATENCY=4.
  - Exactly one valid pulse, 4 cycles after acceptance.
  - Data 32'hABAC_0012.
  - `load_count`=1.
- **Store then load:** STORE 0x0000_0100 ← 0xDEAD_BEEF for 1 cycle, then LOAD 0x0000_0103.
  - Data 0xDEAD_BEEF (low bits ignored).
  - `store_count`=1.
- **Index wrap:** with DEPTH_WORDS=1024, STORE 0x0000_1008 ← 0x1234_5678, then LOAD 0x0000_0008.
  - Data 0x1234_5678.
- **Address change mid-WAIT:** LOAD 0x20 with data 0xAAAA_0001 stored there; switch the address to 0x24 during WAIT.
  - Response is 0xAAAA_0001.
  - Next request sampled only after RESP.
- **Line fill:** four consecutive LOADs 0x40/0x44/0x48/0x4C with valid held.
  - Four pulses spaced exactly LOAD_LATENCY+1 cycles apart, with correct data.
  - `load_count`=4.
- **Reset mid-load:** assert `reset` during WAIT.
  - No valid pulse.
  - Counters 0.
  - A previously stored word now reads 32'hABAC_0012.

Source files
------------

// File: rtl/l2_backing_memory.sv
`default_nettype none
// ============================================================================
// Module   : l2_backing_memory
// Purpose  : Word-organised L2 backing store behind dcache. Loads have a fixed
//            latency and stores take one cycle. Words that have never been
//            written read back as FILL_WORD.
// Revision : 1.0 - initial release
// ============================================================================

package l2_mem_pkg;
    typedef enum logic {
        LOAD  = 1'b0,
        STORE = 1'b1
    } memory_operation_e;
endpackage

module l2_backing_memory
    import l2_mem_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter int              DEPTH_WORDS  = 1024,
    parameter int              LOAD_LATENCY = 4,
    parameter logic [XLEN-1:0] FILL_WORD    = 32'hABAC_0012
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   l2_req_address,
    input  memory_operation_e l2_req_type,
    input  logic              l2_req_valid,
    input  logic [XLEN-1:0]   l2_word_to_store,
    output logic [XLEN-1:0]   l2_fetched_word,
    output logic              l2_fetched_word_valid,
    output logic [31:0]       load_count,
    output logic [31:0]       store_count
);

    localparam int         AW         = $clog2(DEPTH_WORDS);
    localparam logic [7:0] c_LAT_INIT = 8'(LOAD_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      lat_q, lat_d;
    logic [AW-1:0]   idx_q, idx_d;

    logic [AW-1:0]   w_req_idx;
    logic [AW-1:0]   w_rd_idx;
    logic            w_store;
    logic            w_enter_resp;
    logic            w_unused_addr_bits;

    logic [XLEN-1:0]        mem_q [DEPTH_WORDS];
    logic [DEPTH_WORDS-1:0] written_q;

    logic [XLEN-1:0] word_q;
    logic            valid_q;
    logic [31:0]     load_cnt_q;
    logic [31:0]     store_cnt_q;

    assign w_req_idx          = l2_req_address[AW+1:2];
    assign w_unused_addr_bits = ^{l2_req_address[1:0], l2_req_address[XLEN-1:AW+2]};

    // With LOAD_LATENCY==1 the response is captured on the accept edge, so the
    // lookup must use the live request index rather than the latched one.
    assign w_rd_idx = (state_q == S_IDLE) ? w_req_idx : idx_q;

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        idx_d   = idx_q;
        w_store = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (l2_req_valid) begin
                    if (l2_req_type == STORE) begin
                        w_store = 1'b1;
                    end else begin
                        idx_d   = w_req_idx;
                        lat_d   = c_LAT_INIT;
                        state_d = (LOAD_LATENCY == 1) ? S_RESP : S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                lat_d = lat_q - 8'd1;
                if (lat_q <= 8'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        w_enter_resp = (state_d == S_RESP);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            lat_q       <= '0;
            idx_q       <= '0;
            written_q   <= '0;
            word_q      <= '0;
            valid_q     <= 1'b0;
            load_cnt_q  <= '0;
            store_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            idx_q   <= idx_d;
            valid_q <= w_enter_resp;
            // Response registers are loaded on the edge entering RESP so the
            // data and the count are both visible during the RESP cycle.
            if (w_enter_resp) begin
                word_q     <= written_q[w_rd_idx] ? mem_q[w_rd_idx] : FILL_WORD;
                load_cnt_q <= load_cnt_q + 32'd1;
            end
            if (w_store) begin
                written_q[w_req_idx] <= 1'b1;
                store_cnt_q          <= store_cnt_q + 32'd1;
            end
        end
    end

    // Data array is deliberately not reset; the written bits mask stale data.
    always_ff @(posedge clk) begin
        if (reset && w_store) begin
            mem_q[w_req_idx] <= l2_word_to_store;
        end
    end

    assign l2_fetched_word       = word_q;
    assign l2_fetched_word_valid = valid_q;
    assign load_count            = load_cnt_q;
    assign store_count           = store_cnt_q;

endmodule

`default_nettype wire
